axi_read_rr_arbiter: RTL

Round-robin grant controller for the shared AXI read channel of the cache load bus. It arbitrates between N read masters, issues a registered one-hot grant that the master mux uses to steer AR/R signals, and holds that grant for exactly one full transaction, from arbitration through the AR handshake to the last R beat. It also counts R beats against the latched `arlen` and flags burst-length violations.

---
 rtl/axi_bus_pkg.sv | 15 +
 rtl/rr_priority_picker.sv | 36 +++
 rtl/axi_read_rr_arbiter.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/axi_bus_pkg.sv
// Shared definitions for the cache load/store bus arbiters.
package axi_bus_pkg;

    localparam int N_MASTERS_DEF = 3;
    localparam int AXI_LEN_W     = 4;

    // Read arbiter phases: waiting for requests, waiting for the AR
    // handshake, and counting R beats until rlast.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } rd_arb_state_t;

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin picker: first set request bit at or after prio_ptr_i,
// scanning upward with wrap. Purely combinational.
module rr_priority_picker #(
    parameter int N = 3
) (
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] prio_ptr_i,
    output logic [N-1:0]         pick_o,
    output logic [$clog2(N)-1:0] pick_idx_o,
    output logic                 valid_o
);

    localparam int IDX_W = $clog2(N);

    logic             found;
    logic [IDX_W-1:0] cand;

    // Scan the N candidates starting at the pointer; the first hit wins.
    always_comb begin
        pick_o     = '0;
        pick_idx_o = '0;
        found      = 1'b0;
        cand       = '0;
        for (int i = 0; i < N; i++) begin
            cand = IDX_W'((int'(prio_ptr_i) + i) % N);
            if (!found && req_i[cand]) begin
                found        = 1'b1;
                pick_o[cand] = 1'b1;
                pick_idx_o   = cand;
            end
        end
    end

    assign valid_o = found;

endmodule

// File: rtl/axi_read_rr_arbiter.sv
// Round-robin grant controller for the shared AXI read channel. Holds a
// registered one-hot grant for one full transaction (AR through the last R
// beat) and flags R bursts whose length disagrees with the latched arlen.
//
// Handshake: a transfer on AR happens in a cycle where arvalid & arready are
// both high; an R beat happens in a cycle where rvalid & rready are both
// high. Valid without ready is a stall and changes nothing here.
module axi_read_rr_arbiter
    import axi_bus_pkg::*;
#(
    parameter int N_MASTERS = N_MASTERS_DEF,
    parameter int LEN_W     = AXI_LEN_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_MASTERS-1:0]         req,
    output logic [N_MASTERS-1:0]         grnt,
    output logic [$clog2(N_MASTERS)-1:0] owner,
    output logic                         busy,
    input  logic                         arvalid,
    input  logic                         arready,
    input  logic [LEN_W-1:0]             arlen,
    input  logic                         rvalid,
    input  logic                         rready,
    input  logic                         rlast,
    output logic                         len_err,
    output rd_arb_state_t                dbg_state
);

    localparam int IDX_W = $clog2(N_MASTERS);
    localparam int CNT_W = LEN_W + 1;

    rd_arb_state_t      state_q,    state_d;
    logic [N_MASTERS-1:0] grnt_q,   grnt_d;
    logic [IDX_W-1:0]   owner_q,    owner_d;
    logic [IDX_W-1:0]   prio_ptr_q, prio_ptr_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [LEN_W-1:0]   exp_len_q,  exp_len_d;
    logic               len_err_q,  len_err_d;

    logic [N_MASTERS-1:0] pick;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_valid;
    logic               ar_hs;
    logic               r_beat;
    logic [IDX_W-1:0]   next_ptr;
    logic [CNT_W-1:0]   exp_len_ext;

    rr_priority_picker #(
        .N (N_MASTERS)
    ) u_picker (
        .req_i      (req),
        .prio_ptr_i (prio_ptr_q),
        .pick_o     (pick),
        .pick_idx_o (pick_idx),
        .valid_o    (pick_valid)
    );

    assign ar_hs       = arvalid & arready;
    assign r_beat      = rvalid & rready;
    assign exp_len_ext = {1'b0, exp_len_q};
    // Priority moves to the master just after the one that completed.
    assign next_ptr    = (owner_q == IDX_W'(N_MASTERS - 1)) ? '0 : owner_q + IDX_W'(1);

    // Next-state logic: grant on request, latch burst length at AR, count
    // beats and judge the burst length on each R beat.
    always_comb begin
        state_d    = state_q;
        grnt_d     = grnt_q;
        owner_d    = owner_q;
        prio_ptr_d = prio_ptr_q;
        beat_cnt_d = beat_cnt_q;
        exp_len_d  = exp_len_q;
        len_err_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grnt_d  = pick;
                    owner_d = pick_idx;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (ar_hs) begin
                    exp_len_d  = arlen;
                    beat_cnt_d = '0;
                    state_d    = DATA;
                end else if (!req[owner_q]) begin
                    // Abandoned before AR: release without moving priority.
                    grnt_d  = '0;
                    state_d = IDLE;
                end
            end
            DATA: begin
                if (r_beat) begin
                    // Saturate so an overlong burst cannot wrap back into range.
                    if (beat_cnt_q != '1) begin
                        beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    end
                    if (rlast) begin
                        len_err_d  = (beat_cnt_q != exp_len_ext);
                        grnt_d     = '0;
                        prio_ptr_d = next_ptr;
                        state_d    = IDLE;
                    end else begin
                        len_err_d = (beat_cnt_q == exp_len_ext);
                    end
                end
            end
            default: begin
                grnt_d  = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State registers with asynchronous return to the idle, no-grant state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            grnt_q     <= '0;
            owner_q    <= '0;
            prio_ptr_q <= '0;
            beat_cnt_q <= '0;
            exp_len_q  <= '0;
            len_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            grnt_q     <= grnt_d;
            owner_q    <= owner_d;
            prio_ptr_q <= prio_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            exp_len_q  <= exp_len_d;
            len_err_q  <= len_err_d;
        end
    end

    assign grnt      = grnt_q;
    assign owner     = owner_q;
    assign busy      = (state_q != IDLE);
    assign len_err   = len_err_q;
    assign dbg_state = state_q;

endmodule
